dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the core's load/store port: accepts one request at a time, waits a configurable number of cycles, then returns load data or commits store data.
- Replaces the zero-latency combinational dmem so the multicycle and pipelined cores can be tested against realistic memory wait states.
- Byte-addressed, little-endian, 64-bit words, RV64 load/store widths selected by memType (funct3 encoding).

Parameters:
- DEPTH, 1024, number of 64-bit words in the array; power of two.
- LATENCY, 2, cycles from request acceptance to resp_valid; must be >= 1.
- INIT_FILE, "", hex file loaded with $readmemh at elaboration; empty string means no load.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_memType  in  `MemTypeBusBits (3)  access width/sign, funct3 encoding.
- req_addr  in  `DataBusBits (64)  byte address.
- req_wdata  in  `DataBusBits (64)  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: response available.
- resp_rdata  out  `DataBusBits (64)  extended load data; 0 for stores.
- resp_err  out  1  qualified by resp_valid: access was misaligned.

Behaviour:
- Reset (reset low, asynchronous): FSM to IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0. Array contents are not cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture write, memType, addr and wdata; load counter with LATENCY-1; go to BUSY.
  - BUSY: req_ready=0. Decrement the counter each cycle. On the edge where counter==0, perform the access, register resp_rdata and resp_err, and go to RESP.
  - RESP: resp_valid=1 and req_ready=0 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Latency: request accepted at edge N, resp_valid high during the cycle after edge N+LATENCY. A back-to-back request is accepted at the edge ending RESP + 1 idle cycle. req_ready depends only on state.
- Addressing: word index = addr[log2(DEPTH)+2:3]; upper bits are ignored, so addresses wrap modulo DEPTH*8. Byte offset = addr[2:0].
- memType codes and load results:
  - 000 B: byte, sign-extended.
  - 001 H: halfword, sign-extended.
  - 010 W: word, sign-extended.
  - 011 D: doubleword.
  - 100 BU: byte, zero-extended.
  - 101 HU: halfword, zero-extended.
  - 110 WU: word, zero-extended.
  - Stores use 000-011 and write only the addressed bytes via a byte-enable merge. Codes 1xx with req_write=1, and code 111, act as D.
- Store commits on the BUSY to RESP edge only. If reset asserts earlier, the store is dropped and the array is unchanged.
- Loads read the array at the same edge. A store followed by a load to the same address returns the new data.
- Captured request fields are held stable from acceptance to RESP. Input changes after acceptance have no effect.

Optional Feature:
- Macro DIAGV2_DMEM_MISALIGN_ERR_EN.
- Defined: an access whose offset is not a multiple of its size returns resp_err=1 and resp_rdata=0; stores do not write.
- Undefined: offset low bits are forced to natural alignment (H clears bit 0, W clears bits 1:0, D clears bits 2:0); resp_err is tied to 0.

Decomposition:
- diagv2_const.vh gains `MEM_B, `MEM_H, `MEM_W, `MEM_D, `MEM_BU, `MEM_HU, `MEM_WU (3-bit) and the dmem FSM state encodings.
- One combinational sub-module, dmem_lane_align, covers load extract/extend and store byte-enable/merge. The FSM, counter and array stay in dmem_responder.

Test Plan:
- Reset: hold reset low, toggle clk -> req_ready=1, resp_valid=0, resp_rdata=0. Assert reset mid-BUSY on a store -> word unchanged on later readback.
- LATENCY=3: store D 0x1122334455667788 at 0x40, then load D from 0x40 -> resp_valid 3 cycles after each accept; rdata=0x1122334455667788; req_ready low for 4 cycles per request.
- Byte/sign: load B at 0x47 -> 0x0000000000000011. Store B 0x80 at 0x41, then load B 0x41 -> 0xFFFFFFFFFFFFFF80 and load BU 0x41 -> 0x80.
- Partial store: store H 0xBEEF at 0x44 -> load D 0x40 = 0x1122BEEF55668088; other bytes untouched.
- Wrap: DEPTH=1024, store W 0xCAFEF00D at 0x2040, then load WU 0x40 -> 0x00000000CAFEF00D.
- Misaligned: load W at 0x42 -> with the macro, resp_err=1 and rdata=0; without it, reads from 0x40 (0x55668088 sign-extended = 0x0000000055668088) with resp_err=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants, FSM state type and access-size helper for the data-memory responder.
// Build option used by dmem_lane_align: DIAGV2_DMEM_MISALIGN_ERR_EN.
package dmem_responder_pkg;

    localparam int DataBusBits    = 64;
    localparam int MemTypeBusBits = 3;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_RESP = 2'd2
    } dmemState_e;

    // log2 of the access size in bytes; stores with 1xx and code 111 behave as D.
    function automatic logic [1:0] accessSizeLog2(input logic isWrite, input logic [2:0] memType);
        if (memType == 3'b111 || (isWrite && memType[2])) begin
            return 2'd3;
        end
        return memType[1:0];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane logic: load extract/extend and store byte-enable merge within one 64-bit word.
// DIAGV2_DMEM_MISALIGN_ERR_EN: flag misaligned accesses instead of forcing natural alignment.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic                      isWrite,
    input  logic [MemTypeBusBits-1:0] memType,
    input  logic [2:0]                offset,
    input  logic [DataBusBits-1:0]    rawWord,
    input  logic [DataBusBits-1:0]    wdata,
    output logic [DataBusBits-1:0]    loadData,
    output logic [DataBusBits-1:0]    mergedWord,
    output logic                      misaligned
);

    logic [1:0]             sizeLog2;
    logic [2:0]             sizeMask;
    logic [2:0]             laneOff;
    logic [7:0]             byteEnBase;
    logic [7:0]             byteEn;
    logic [DataBusBits-1:0] bitEn;
    logic [DataBusBits-1:0] shifted;

    always_comb begin
        sizeLog2   = accessSizeLog2(isWrite, memType);
        sizeMask   = 3'((4'd1 << sizeLog2) - 4'd1);
        laneOff    = offset & ~sizeMask;
`ifdef DIAGV2_DMEM_MISALIGN_ERR_EN
        misaligned = |(offset & sizeMask);
`else
        misaligned = 1'b0;
`endif
        case (sizeLog2)
            2'd0:    byteEnBase = 8'h01;
            2'd1:    byteEnBase = 8'h03;
            2'd2:    byteEnBase = 8'h0F;
            default: byteEnBase = 8'hFF;
        endcase
        byteEn = byteEnBase << laneOff;
        bitEn  = '0;
        for (int i = 0; i < 8; i++) begin
            bitEn[8*i +: 8] = {8{byteEn[i]}};
        end
        mergedWord = (rawWord & ~bitEn) | ((wdata << {laneOff, 3'b000}) & bitEn);

        // Loads: bring the addressed lane down to bit 0, then extend by memType[2].
        shifted = rawWord >> {laneOff, 3'b000};
        case (sizeLog2)
            2'd0:    loadData = memType[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1:    loadData = memType[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2:    loadData = memType[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multicycle data-memory responder: one request at a time, LATENCY cycles to a one-cycle response.
// DIAGV2_DMEM_MISALIGN_ERR_EN enables misaligned-access errors (see dmem_lane_align).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [MemTypeBusBits-1:0] req_memType,
    input  logic [DataBusBits-1:0]    req_addr,
    input  logic [DataBusBits-1:0]    req_wdata,
    output logic                      resp_valid,
    output logic [DataBusBits-1:0]    resp_rdata,
    output logic                      resp_err,
    output dmemState_e                dbgState
);

    localparam int IdxBits = $clog2(DEPTH);
    localparam int CntBits = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is a pure function of state, and resp_valid is a single-cycle pulse
    // that the requester must take (no response backpressure).
    dmemState_e                state;
    dmemState_e                stateNext;
    logic [CntBits-1:0]        cnt;
    logic                      capWrite;
    logic [MemTypeBusBits-1:0] capMemType;
    logic [IdxBits-1:0]        capIdx;
    logic [2:0]                capOff;
    logic [DataBusBits-1:0]    capWdata;

    logic [DataBusBits-1:0]    mem [DEPTH];
    logic [DataBusBits-1:0]    rawWord;
    logic [DataBusBits-1:0]    loadData;
    logic [DataBusBits-1:0]    mergedWord;
    logic                      misaligned;
    logic                      accessNow;
    logic                      unusedAddrBits;

    assign unusedAddrBits = ^req_addr[DataBusBits-1:IdxBits+3];
    assign rawWord        = mem[capIdx];
    assign accessNow      = (state == DMEM_BUSY) && (cnt == '0);
    assign dbgState       = state;

    dmem_lane_align u_lane (
        .isWrite    (capWrite),
        .memType    (capMemType),
        .offset     (capOff),
        .rawWord    (rawWord),
        .wdata      (capWdata),
        .loadData   (loadData),
        .mergedWord (mergedWord),
        .misaligned (misaligned)
    );

    always_comb begin
        stateNext  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            DMEM_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) stateNext = DMEM_BUSY;
            end
            DMEM_BUSY: begin
                if (cnt == '0) stateNext = DMEM_RESP;
            end
            DMEM_RESP: begin
                resp_valid = 1'b1;
                stateNext  = DMEM_IDLE;
            end
            default: stateNext = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DMEM_IDLE;
            cnt        <= '0;
            capWrite   <= 1'b0;
            capMemType <= '0;
            capIdx     <= '0;
            capOff     <= '0;
            capWdata   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == DMEM_IDLE && req_valid) begin
                capWrite   <= req_write;
                capMemType <= req_memType;
                capIdx     <= req_addr[IdxBits+2:3];
                capOff     <= req_addr[2:0];
                capWdata   <= req_wdata;
                cnt        <= CntBits'(LATENCY - 1);
            end else if (state == DMEM_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (accessNow) begin
                resp_err   <= misaligned;
                resp_rdata <= (capWrite || misaligned) ? '0 : loadData;
            end
        end
    end

    // Store commit happens only on the BUSY->RESP edge; a reset before then drops it.
    always_ff @(posedge clk) begin
        if (accessNow && capWrite && !misaligned) begin
            mem[capIdx] <= mergedWord;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=3, DEPTH=1024) with a byte-array reference model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 3;
    localparam int NBYTES  = DEPTH * 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_memType = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    dmemState_e  dbgState;

    int nVec  = 0;
    int nFail = 0;

    logic [7:0]  refMem [NBYTES];
    logic [63:0] exp_q[$];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .INIT_FILE("")) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_memType (req_memType),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .dbgState    (dbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Byte-addressed little-endian memory; addresses wrap modulo NBYTES.
    task automatic model_access(input logic wr, input logic [2:0] mt, input logic [63:0] addr,
                                input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
        int n;
        int a;
        n = (mt == 3'b111 || (wr && mt[2])) ? 8 : (1 << mt[1:0]);
        a = int'(addr % 64'(NBYTES));
        rdata = '0;
        err   = 1'b0;
        if (a % n != 0) begin
`ifdef DIAGV2_DMEM_MISALIGN_ERR_EN
            err = 1'b1;
            return;
`else
            a = a - (a % n);
`endif
        end
        if (wr) begin
            for (int i = 0; i < n; i++) refMem[a + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) rdata[8*i +: 8] = refMem[a + i];
            if (!mt[2] && n < 8 && rdata[8*n - 1]) begin
                for (int j = 8*n; j < 64; j++) rdata[j] = 1'b1;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Presents one request, scrambles inputs after acceptance, and measures the response.
    task automatic drive_req(input logic wr, input logic [2:0] mt, input logic [63:0] addr,
                             input logic [63:0] wdata, output logic [63:0] rdata, output logic err,
                             output int lat, output int readyLow, output int waitCyc);
        int k;
        rdata = 'x; err = 1'bx; lat = -1; readyLow = 0; waitCyc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_memType = mt; req_addr = addr; req_wdata = wdata;
        while (!req_ready && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!req_ready) begin
            nVec++; nFail++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_write   = 1'($urandom);
        req_memType = 3'($urandom);
        req_addr    = {$urandom, $urandom};
        req_wdata   = {$urandom, $urandom};
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (!req_ready) readyLow++;
            if (resp_valid) begin
                rdata = resp_rdata;
                err   = resp_err;
                lat   = k - 1;
                break;
            end
        end
        if (lat < 0) begin
            nVec++; nFail++;
            $display("FAIL resp_timeout: resp_valid stayed %b, required 1", resp_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nVec++; if (req_ready !== 1'b1) begin nFail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
        nVec++; if (resp_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b required 0", resp_valid); end
        nVec++; if (resp_rdata !== 64'd0) begin nFail++; $display("FAIL reset_rdata: got %h required 0", resp_rdata); end
        nVec++; if (resp_err !== 1'b0) begin nFail++; $display("FAIL reset_err: got %b required 0", resp_err); end
        reset = 1'b1;
    endtask

    task automatic test_latency();
        logic [63:0] rd, mr; logic er, me; int lat, rl, wc;
        model_access(1'b1, MEM_D, 64'h40, 64'h1122334455667788, mr, me);
        drive_req(1'b1, MEM_D, 64'h40, 64'h1122334455667788, rd, er, lat, rl, wc);
        nVec++; if (lat !== LATENCY) begin nFail++; $display("FAIL store_latency: got %0d required %0d", lat, LATENCY); end
        nVec++; if (rl !== LATENCY + 1) begin nFail++; $display("FAIL store_ready_low: got %0d required %0d", rl, LATENCY + 1); end
        nVec++; if (rd !== 64'd0) begin nFail++; $display("FAIL store_rdata: got %h required 0", rd); end
        model_access(1'b0, MEM_D, 64'h40, 64'h0, mr, me);
        drive_req(1'b0, MEM_D, 64'h40, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (lat !== LATENCY) begin nFail++; $display("FAIL load_latency: got %0d required %0d", lat, LATENCY); end
        nVec++; if (rl !== LATENCY + 1) begin nFail++; $display("FAIL load_ready_low: got %0d required %0d", rl, LATENCY + 1); end
        nVec++; if (rd !== 64'h1122334455667788) begin nFail++; $display("FAIL load_d: got %h required 1122334455667788", rd); end
        nVec++; if (er !== 1'b0) begin nFail++; $display("FAIL load_d_err: got %b required 0", er); end
    endtask

    task automatic test_byte_sign();
        logic [63:0] rd, mr; logic er, me; int lat, rl, wc;
        model_access(1'b0, MEM_B, 64'h47, 64'h0, mr, me);
        drive_req(1'b0, MEM_B, 64'h47, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'h11) begin nFail++; $display("FAIL load_b_47: got %h required 0000000000000011", rd); end
        model_access(1'b1, MEM_B, 64'h41, 64'h80, mr, me);
        drive_req(1'b1, MEM_B, 64'h41, 64'h80, rd, er, lat, rl, wc);
        model_access(1'b0, MEM_B, 64'h41, 64'h0, mr, me);
        drive_req(1'b0, MEM_B, 64'h41, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin nFail++; $display("FAIL load_b_41: got %h required ffffffffffffff80", rd); end
        model_access(1'b0, MEM_BU, 64'h41, 64'h0, mr, me);
        drive_req(1'b0, MEM_BU, 64'h41, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'h80) begin nFail++; $display("FAIL load_bu_41: got %h required 0000000000000080", rd); end
    endtask

    task automatic test_partial_store();
        logic [63:0] rd, mr; logic er, me; int lat, rl, wc;
        model_access(1'b1, MEM_H, 64'h44, 64'hBEEF, mr, me);
        drive_req(1'b1, MEM_H, 64'h44, 64'hBEEF, rd, er, lat, rl, wc);
        model_access(1'b0, MEM_D, 64'h40, 64'h0, mr, me);
        drive_req(1'b0, MEM_D, 64'h40, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'h1122BEEF55668088) begin nFail++; $display("FAIL partial_store: got %h required 1122beef55668088", rd); end
    endtask

    task automatic test_misaligned();
        logic [63:0] rd, mr, expD; logic er, me, expErr; int lat, rl, wc;
        model_access(1'b0, MEM_W, 64'h42, 64'h0, mr, me);
        drive_req(1'b0, MEM_W, 64'h42, 64'h0, rd, er, lat, rl, wc);
`ifdef DIAGV2_DMEM_MISALIGN_ERR_EN
        nVec++; if (er !== 1'b1) begin nFail++; $display("FAIL misaligned_load_err: got %b required 1", er); end
        nVec++; if (rd !== 64'd0) begin nFail++; $display("FAIL misaligned_load_rdata: got %h required 0", rd); end
        expErr = 1'b1;
        expD   = 64'h1122BEEF55668088;
`else
        nVec++; if (er !== 1'b0) begin nFail++; $display("FAIL misaligned_load_err: got %b required 0", er); end
        nVec++; if (rd !== 64'h0000000055668088) begin nFail++; $display("FAIL misaligned_load_rdata: got %h required 0000000055668088", rd); end
        expErr = 1'b0;
        expD   = 64'h1122BEEF12348088;
`endif
        model_access(1'b1, MEM_H, 64'h43, 64'h1234, mr, me);
        drive_req(1'b1, MEM_H, 64'h43, 64'h1234, rd, er, lat, rl, wc);
        nVec++; if (er !== expErr) begin nFail++; $display("FAIL misaligned_store_err: got %b required %b", er, expErr); end
        model_access(1'b0, MEM_D, 64'h40, 64'h0, mr, me);
        drive_req(1'b0, MEM_D, 64'h40, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== expD) begin nFail++; $display("FAIL misaligned_store_readback: got %h required %h", rd, expD); end
    endtask

    task automatic test_wrap();
        logic [63:0] rd, mr; logic er, me; int lat, rl, wc;
        model_access(1'b1, MEM_W, 64'h2040, 64'hCAFEF00D, mr, me);
        drive_req(1'b1, MEM_W, 64'h2040, 64'hCAFEF00D, rd, er, lat, rl, wc);
        model_access(1'b0, MEM_WU, 64'h40, 64'h0, mr, me);
        drive_req(1'b0, MEM_WU, 64'h40, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'h00000000CAFEF00D) begin nFail++; $display("FAIL wrap_load_wu: got %h required 00000000cafef00d", rd); end
        model_access(1'b0, MEM_D, 64'h40, 64'h0, mr, me);
        drive_req(1'b0, MEM_D, 64'h40, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'h1122BEEFCAFEF00D) begin nFail++; $display("FAIL wrap_load_d: got %h required 1122beefcafef00d", rd); end
    endtask

    task automatic test_reset_mid_busy();
        logic [63:0] rd; logic er; int lat, rl, wc;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_memType = MEM_D;
        req_addr = 64'h40; req_wdata = 64'hDEADBEEFDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        nVec++; if (req_ready !== 1'b1) begin nFail++; $display("FAIL midbusy_reset_ready: got %b required 1", req_ready); end
        nVec++; if (resp_valid !== 1'b0) begin nFail++; $display("FAIL midbusy_reset_valid: got %b required 0", resp_valid); end
        @(negedge clk);
        reset = 1'b1;
        drive_req(1'b0, MEM_D, 64'h40, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'h1122BEEFCAFEF00D) begin nFail++; $display("FAIL midbusy_store_dropped: got %h required 1122beefcafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd, mr; logic er, me; int lat, rl, wc;
        model_access(1'b0, MEM_H, 64'h46, 64'h0, mr, me);
        drive_req(1'b0, MEM_H, 64'h46, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (rd !== 64'h0000000000001122) begin nFail++; $display("FAIL b2b_first: got %h required 0000000000001122", rd); end
        model_access(1'b0, MEM_HU, 64'h44, 64'h0, mr, me);
        drive_req(1'b0, MEM_HU, 64'h44, 64'h0, rd, er, lat, rl, wc);
        nVec++; if (wc !== 0) begin nFail++; $display("FAIL b2b_wait: got %0d required 0", wc); end
        nVec++; if (rd !== 64'h000000000000BEEF) begin nFail++; $display("FAIL b2b_second: got %h required 000000000000beef", rd); end
        nVec++; if (lat !== LATENCY) begin nFail++; $display("FAIL b2b_latency: got %0d required %0d", lat, LATENCY); end
    endtask

    task automatic test_random();
        logic [63:0] rd, mr, addr, wd, expRd; logic er, me, wr; logic [2:0] mt; int lat, rl, wc;
        for (int w = 0; w < 32; w++) begin
            wd = {$urandom, $urandom};
            model_access(1'b1, MEM_D, 64'h400 + 64'(w * 8), wd, mr, me);
            drive_req(1'b1, MEM_D, 64'h400 + 64'(w * 8), wd, rd, er, lat, rl, wc);
        end
        for (int t = 0; t < 80; t++) begin
            wr   = 1'($urandom_range(0, 1));
            mt   = 3'($urandom_range(0, 7));
            addr = 64'($urandom_range(0, 3)) * 64'h2000 + 64'h400
                 + 64'($urandom_range(0, 31) * 8) + 64'($urandom_range(0, 7));
            wd   = {$urandom, $urandom};
            model_access(wr, mt, addr, wd, mr, me);
            exp_q.push_back(mr);
            drive_req(wr, mt, addr, wd, rd, er, lat, rl, wc);
            expRd = exp_q.pop_front();
            nVec++; if (rd !== expRd) begin nFail++; $display("FAIL rand_rdata[%0d] wr=%b mt=%0d addr=%h: got %h required %h", t, wr, mt, addr, rd, expRd); end
            nVec++; if (er !== me) begin nFail++; $display("FAIL rand_err[%0d]: got %b required %b", t, er, me); end
            nVec++; if (lat !== LATENCY) begin nFail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", t, lat, LATENCY); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_latency();
        test_byte_sign();
        test_partial_store();
        test_misaligned();
        test_wrap();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
